// File: rtl/apb_pkg.sv
// rtl/apb_pkg.sv - shared APB requester types, default widths and alignment helper
package apb_pkg;

    localparam int APB_ADDR_W = 8;
    localparam int APB_DATA_W = 32;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_ACCESS = 2'd2,
        ST_RESP   = 2'd3
    } apb_state_t;

    // A transfer is only issued for word-aligned byte addresses.
    function automatic logic apb_aligned(input logic [1:0] addr_lsb);
        return (addr_lsb == 2'b00);
    endfunction

endpackage

// File: rtl/apb_master.sv
// rtl/apb_master.sv - APB requester with command/response handshakes and PREADY watchdog
module apb_master
    import apb_pkg::*;
#(
    parameter int ADDR_W  = APB_ADDR_W,
    parameter int DATA_W  = APB_DATA_W,
    parameter int TIMEOUT = 16
) (
    input  logic              PCLK,
    input  logic              PRESETn,

    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [DATA_W-1:0] cmd_wdata,

    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic              rsp_timeout,

    output logic [ADDR_W-1:0] PADDR,
    output logic              PSEL,
    output logic              PENABLE,
    output logic              PWRITE,
    output logic [DATA_W-1:0] PWDATA,
    input  logic [DATA_W-1:0] PRDATA,
    input  logic              PREADY,
    input  logic              PSLVERR
);

    localparam int               CNT_W    = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    apb_state_t       state;
    apb_state_t       state_nxt;
    logic [CNT_W-1:0] wd_cnt;
    logic             cmd_fire;
    logic             cmd_aligned;
    logic             wd_expire;

    assign cmd_fire    = (state == ST_IDLE) && cmd_valid;
    assign cmd_aligned = apb_aligned(cmd_addr[1:0]);
    // Last permitted wait cycle: without PREADY now, the transfer is abandoned.
    assign wd_expire   = (state == ST_ACCESS) && !PREADY && (wd_cnt == CNT_LAST);

    // State register; reset drops PSEL/PENABLE/rsp_valid at once since they decode from state.
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state and state-decoded handshake/bus controls (no input-to-output paths).
    always_comb begin
        state_nxt = state;
        cmd_ready = 1'b0;
        rsp_valid = 1'b0;
        PSEL      = 1'b0;
        PENABLE   = 1'b0;
        unique case (state)
            ST_IDLE: begin
                cmd_ready = 1'b1;
                if (cmd_valid) begin
                    state_nxt = cmd_aligned ? ST_SETUP : ST_RESP;
                end
            end
            ST_SETUP: begin
                PSEL      = 1'b1;
                state_nxt = ST_ACCESS;
            end
            ST_ACCESS: begin
                PSEL    = 1'b1;
                PENABLE = 1'b1;
                if (PREADY || wd_expire) begin
                    state_nxt = ST_RESP;
                end
            end
            ST_RESP: begin
                rsp_valid = 1'b1;
                if (rsp_ready) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    // Watchdog: counts consecutive ACCESS cycles without PREADY, restarted in SETUP.
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            wd_cnt <= '0;
        end else if (state == ST_SETUP) begin
            wd_cnt <= '0;
        end else if ((state == ST_ACCESS) && !PREADY) begin
            wd_cnt <= wd_cnt + CNT_W'(1);
        end
    end

    // Bus request fields: loaded only for aligned commands and held for the whole transfer.
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            PADDR  <= '0;
            PWRITE <= 1'b0;
            PWDATA <= '0;
        end else if (cmd_fire && cmd_aligned) begin
            PADDR  <= cmd_addr;
            PWRITE <= cmd_write;
            PWDATA <= cmd_wdata;
        end
    end

    // Response fields: written when the outcome is known, then held through RESP.
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            rsp_rdata   <= '0;
            rsp_err     <= 1'b0;
            rsp_timeout <= 1'b0;
        end else if (cmd_fire && !cmd_aligned) begin
            rsp_rdata   <= '0;
            rsp_err     <= 1'b1;
            rsp_timeout <= 1'b0;
        end else if ((state == ST_ACCESS) && PREADY) begin
            // Read data is only meaningful for a successful read.
            rsp_rdata   <= (PWRITE || PSLVERR) ? '0 : PRDATA;
            rsp_err     <= PSLVERR;
            rsp_timeout <= 1'b0;
        end else if (wd_expire) begin
            rsp_rdata   <= '0;
            rsp_err     <= 1'b1;
            rsp_timeout <= 1'b1;
        end
    end

endmodule
